// File: rtl/p4paxos_axis_pkg.sv
// rtl/p4paxos_axis_pkg.sv - shared widths and arbiter state encoding
package p4paxos_axis_pkg;

    localparam int DATA_W_DEF = 256;
    localparam int KEEP_W_DEF = 32;
    localparam int USER_W_DEF = 128;
    localparam int CNT_W      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_t;

endpackage

// File: rtl/axis_rr_pick.sv
// rtl/axis_rr_pick.sv - two-way round-robin selector
module axis_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic pick0,
    output logic pick1
);

    // On a tie the requester that was not served last wins.
    assign pick0 = req0 & (~req1 | last_served);
    assign pick1 = req1 & (~req0 | ~last_served);

endmodule

// File: rtl/tuser_pkt_arb.sv
// rtl/tuser_pkt_arb.sv - packet-granular two-requester AXIS arbiter
module tuser_pkt_arb
    import p4paxos_axis_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int KEEP_W = KEEP_W_DEF,
    parameter int USER_W = USER_W_DEF
) (
    input  logic              arb_aclk,
    input  logic              arb_arst,

    input  logic              arb_s0_valid,
    output logic              arb_s0_ready,
    input  logic [DATA_W-1:0] arb_s0_data,
    input  logic [KEEP_W-1:0] arb_s0_keep,
    input  logic              arb_s0_tlast,
    input  logic [USER_W-1:0] arb_s0_tuser,

    input  logic              arb_s1_valid,
    output logic              arb_s1_ready,
    input  logic [DATA_W-1:0] arb_s1_data,
    input  logic [KEEP_W-1:0] arb_s1_keep,
    input  logic              arb_s1_tlast,
    input  logic [USER_W-1:0] arb_s1_tuser,

    output logic              arb_m_valid,
    input  logic              arb_m_ready,
    output logic [DATA_W-1:0] arb_m_data,
    output logic [KEEP_W-1:0] arb_m_keep,
    output logic              arb_m_tlast,
    output logic [USER_W-1:0] arb_m_tuser,

    output logic [CNT_W-1:0]  arb_pkt_cnt0,
    output logic [CNT_W-1:0]  arb_pkt_cnt1,
    output logic              arb_busy
);

    arb_state_t       state;
    arb_state_t       state_next;
    logic             last_served;
    logic             pick0;
    logic             pick1;
    logic             last0_acc;
    logic             last1_acc;
    logic [CNT_W-1:0] pkt_cnt0_q;
    logic [CNT_W-1:0] pkt_cnt1_q;

    axis_rr_pick u_pick (
        .req0        (arb_s0_valid),
        .req1        (arb_s1_valid),
        .last_served (last_served),
        .pick0       (pick0),
        .pick1       (pick1)
    );

    assign last0_acc = (state == GNT0) && arb_s0_valid && arb_m_ready && arb_s0_tlast;
    assign last1_acc = (state == GNT1) && arb_s1_valid && arb_m_ready && arb_s1_tlast;

    assign arb_pkt_cnt0 = pkt_cnt0_q;
    assign arb_pkt_cnt1 = pkt_cnt1_q;

    always_ff @(posedge arb_aclk) begin
        if (arb_arst) begin
            state       <= IDLE;
            last_served <= 1'b1;
            pkt_cnt0_q  <= '0;
            pkt_cnt1_q  <= '0;
        end else begin
            state <= state_next;
            if (last0_acc) begin
                last_served <= 1'b0;
                pkt_cnt0_q  <= arb_pkt_cnt0 + 32'd1;
            end
            if (last1_acc) begin
                last_served <= 1'b1;
                pkt_cnt1_q  <= arb_pkt_cnt1 + 32'd1;
            end
        end
    end

    // Datapath is a pure mux on the granted slave; nothing is registered.
    always_comb begin
        state_next   = state;
        arb_m_valid  = 1'b0;
        arb_m_data   = '0;
        arb_m_keep   = '0;
        arb_m_tlast  = 1'b0;
        arb_m_tuser  = '0;
        arb_s0_ready = 1'b0;
        arb_s1_ready = 1'b0;
        arb_busy     = 1'b0;
        case (state)
            IDLE: begin
                if (pick0) begin
                    state_next = GNT0;
                end else if (pick1) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                arb_busy     = 1'b1;
                arb_m_valid  = arb_s0_valid;
                arb_m_data   = arb_s0_data;
                arb_m_keep   = arb_s0_keep;
                arb_m_tlast  = arb_s0_tlast;
                arb_m_tuser  = arb_s0_tuser;
                arb_s0_ready = arb_m_ready;
                if (last0_acc) begin
                    state_next = arb_s1_valid ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                arb_busy     = 1'b1;
                arb_m_valid  = arb_s1_valid;
                arb_m_data   = arb_s1_data;
                arb_m_keep   = arb_s1_keep;
                arb_m_tlast  = arb_s1_tlast;
                arb_m_tuser  = arb_s1_tuser;
                arb_s1_ready = arb_m_ready;
                if (last1_acc) begin
                    state_next = arb_s0_valid ? GNT0 : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tuser_pkt_arb.sv
// tb/tb_tuser_pkt_arb.sv - scoreboard bench for tuser_pkt_arb
module tb_tuser_pkt_arb;

    localparam int DW = 256;
    localparam int KW = 32;
    localparam int UW = 128;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          tlast;
        logic [UW-1:0] tuser;
    } beat_t;

    logic          clk = 1'b0;
    logic          arst;
    logic          s0_valid, s0_ready, s0_tlast;
    logic [DW-1:0] s0_data;
    logic [KW-1:0] s0_keep;
    logic [UW-1:0] s0_tuser;
    logic          s1_valid, s1_ready, s1_tlast;
    logic [DW-1:0] s1_data;
    logic [KW-1:0] s1_keep;
    logic [UW-1:0] s1_tuser;
    logic          m_valid, m_ready, m_tlast;
    logic [DW-1:0] m_data;
    logic [KW-1:0] m_keep;
    logic [UW-1:0] m_tuser;
    logic [31:0]   cnt0, cnt1;
    logic          busy;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp0[$];
    beat_t exp1[$];
    int    done_order[$];
    bit    mon_en = 1'b0;
    bit    idle_en = 1'b0;
    int    idle_cnt = 0;
    bit    pkt_done;

    always #5 clk = ~clk;

    tuser_pkt_arb dut (
        .arb_aclk     (clk),
        .arb_arst     (arst),
        .arb_s0_valid (s0_valid),
        .arb_s0_ready (s0_ready),
        .arb_s0_data  (s0_data),
        .arb_s0_keep  (s0_keep),
        .arb_s0_tlast (s0_tlast),
        .arb_s0_tuser (s0_tuser),
        .arb_s1_valid (s1_valid),
        .arb_s1_ready (s1_ready),
        .arb_s1_data  (s1_data),
        .arb_s1_keep  (s1_keep),
        .arb_s1_tlast (s1_tlast),
        .arb_s1_tuser (s1_tuser),
        .arb_m_valid  (m_valid),
        .arb_m_ready  (m_ready),
        .arb_m_data   (m_data),
        .arb_m_keep   (m_keep),
        .arb_m_tlast  (m_tlast),
        .arb_m_tuser  (m_tuser),
        .arb_pkt_cnt0 (cnt0),
        .arb_pkt_cnt1 (cnt1),
        .arb_busy     (busy)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t rand_beat(input bit last);
        beat_t b;
        for (int i = 0; i < DW / 32; i++) b.data[i*32 +: 32] = $urandom;
        b.keep = $urandom;
        for (int i = 0; i < UW / 32; i++) b.tuser[i*32 +: 32] = $urandom;
        b.tlast = last;
        return b;
    endfunction

    task automatic drive(input int src, input beat_t b, input logic v);
        if (src == 0) begin
            s0_valid = v; s0_data = b.data; s0_keep = b.keep; s0_tlast = b.tlast; s0_tuser = b.tuser;
        end else begin
            s1_valid = v; s1_data = b.data; s1_keep = b.keep; s1_tlast = b.tlast; s1_tuser = b.tuser;
        end
    endtask

    // Present one beat, record it as expected, hold it until the handshake.
    task automatic send_beat(input int src, input beat_t b);
        logic acc;
        int   n = 0;
        if (src == 0) exp0.push_back(b); else exp1.push_back(b);
        drive(src, b, 1'b1);
        do begin
            @(negedge clk);
            acc = (src == 0) ? s0_ready : s1_ready;
            @(posedge clk);
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("handshake_timeout", 256'(0), 256'(1));
        #1;
    endtask

    task automatic send_pkt(input int src, input int beats);
        for (int i = 0; i < beats; i++) send_beat(src, rand_beat(i == beats - 1));
        drive(src, beat_t'(0), 1'b0);
    endtask

    task automatic do_reset();
        arst = 1'b1;
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
        done_order.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            beat_t got, want;
            chk("ready_exclusive", 256'(s0_ready & s1_ready), 256'(0));
            if (idle_en && !busy) idle_cnt++;
            if (m_valid && m_ready) begin
                got = {m_data, m_keep, m_tlast, m_tuser};
                if (s0_ready && exp0.size() > 0) begin
                    want = exp0.pop_front();
                    if (m_tlast) done_order.push_back(0);
                end else if (s1_ready && exp1.size() > 0) begin
                    want = exp1.pop_front();
                    if (m_tlast) done_order.push_back(1);
                end else begin
                    want = ~got;
                end
                chk("beat_data", got.data, want.data);
                chk("beat_keep", 256'(got.keep), 256'(want.keep));
                chk("beat_tlast", 256'(got.tlast), 256'(want.tlast));
                chk("beat_tuser", 256'(got.tuser), 256'(want.tuser));
            end
        end
    end

    initial begin
        logic pat [4];
        time  t0, t1;
        beat_t b;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        drive(0, beat_t'(0), 1'b0);
        drive(1, beat_t'(0), 1'b0);
        m_ready = 1'b1;
        do_reset();
        arst = 1'b1;
        @(negedge clk);
        chk("rst_m_valid", 256'(m_valid), 256'(0));
        chk("rst_s0_ready", 256'(s0_ready), 256'(0));
        chk("rst_s1_ready", 256'(s1_ready), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_cnt0", 256'(cnt0), 256'(0));
        chk("rst_cnt1", 256'(cnt1), 256'(0));
        chk("rst_m_data", m_data, 256'(0));
        chk("rst_m_tuser", 256'(m_tuser), 256'(0));
        @(posedge clk); #1 arst = 1'b0;
        mon_en = 1'b1;

        // Single 3-beat packet from s0, one-cycle grant latency.
        fork
            send_pkt(0, 3);
            begin
                @(negedge clk); chk("arb_cycle_busy", 256'(busy), 256'(0));
                @(negedge clk); chk("grant0_ready", 256'(s0_ready), 256'(1));
            end
        join
        @(negedge clk);
        chk("t1_cnt0", 256'(cnt0), 256'(1));
        chk("t1_idle", 256'(busy), 256'(0));
        @(posedge clk); #1;

        // Tie from IDLE: s0, s1, s0 with no idle cycle between grants.
        do_reset();
        idle_cnt = 0; idle_en = 1'b1;
        fork
            begin send_pkt(0, 2); send_pkt(0, 2); end
            send_pkt(1, 2);
        join
        idle_en = 1'b0;
        chk("t2_idle_cycles", 256'(idle_cnt), 256'(1));
        chk("t2_npkts", 256'(done_order.size()), 256'(3));
        if (done_order.size() == 3) begin
            chk("t2_order0", 256'(done_order[0]), 256'(0));
            chk("t2_order1", 256'(done_order[1]), 256'(1));
            chk("t2_order2", 256'(done_order[2]), 256'(0));
        end
        @(negedge clk);
        chk("t2_cnt0", 256'(cnt0), 256'(2));
        chk("t2_cnt1", 256'(cnt1), 256'(1));
        @(posedge clk); #1;

        // Backpressure on a 4-beat s1 packet.
        do_reset();
        pkt_done = 1'b0;
        fork
            begin send_pkt(1, 4); pkt_done = 1'b1; end
            begin
                int k = 0;
                while (!pkt_done) begin
                    m_ready = pat[k % 4]; k++;
                    @(posedge clk); #1;
                end
                m_ready = 1'b1;
            end
            while (!pkt_done) begin
                @(negedge clk);
                if (busy) chk("t3_s1_tracks_m", 256'(s1_ready), 256'(m_ready));
                chk("t3_s0_ready_low", 256'(s0_ready), 256'(0));
            end
        join
        @(negedge clk);
        chk("t3_cnt1", 256'(cnt1), 256'(1));
        @(posedge clk); #1;

        // Back-to-back single-beat s0 packets: one packet every two cycles.
        do_reset();
        t0 = $time;
        for (int i = 0; i < 4; i++) send_pkt(0, 1);
        t1 = $time;
        chk("t4_cycles", 256'(int'((t1 - t0) / 10)), 256'(8));
        @(negedge clk);
        chk("t4_cnt0", 256'(cnt0), 256'(4));
        @(posedge clk); #1;

        // Counter wrap on s1.
        force dut.arb_pkt_cnt1 = 32'hFFFF_FFFF;
        send_pkt(1, 1);
        release dut.arb_pkt_cnt1;
        #1;
        chk("t5_cnt1_wrap", 256'(cnt1), 256'(0));

        // Reset on beat 2 of a 5-beat s0 packet, after s0 was served last.
        send_pkt(0, 1);
        send_beat(0, rand_beat(1'b0));
        b = rand_beat(1'b0);
        exp0.push_back(b);
        drive(0, b, 1'b1);
        arst = 1'b1;
        @(posedge clk); #1;
        drive(0, beat_t'(0), 1'b0);
        @(negedge clk);
        chk("t6_busy", 256'(busy), 256'(0));
        chk("t6_m_valid", 256'(m_valid), 256'(0));
        chk("t6_s0_ready", 256'(s0_ready), 256'(0));
        chk("t6_s1_ready", 256'(s1_ready), 256'(0));
        chk("t6_cnt0", 256'(cnt0), 256'(0));
        chk("t6_cnt1", 256'(cnt1), 256'(0));
        @(posedge clk); #1 arst = 1'b0;
        done_order.delete();
        fork
            send_pkt(0, 1);
            send_pkt(1, 1);
        join
        chk("t6_npkts", 256'(done_order.size()), 256'(2));
        if (done_order.size() == 2) begin
            chk("t6_tie_first", 256'(done_order[0]), 256'(0));
            chk("t6_tie_second", 256'(done_order[1]), 256'(1));
        end

        repeat (2) @(posedge clk);
        chk("exp0_drained", 256'(exp0.size()), 256'(0));
        chk("exp1_drained", 256'(exp1.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tuser_pkt_arb.md
TUSER_PKT_ARB -- requirements
Module: tuser_pkt_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 256, AXIS data width in bits.
REQ-002 SHALL have parameter KEEP_W, default 32, AXIS keep width (DATA_W/8).
REQ-003 SHALL have parameter USER_W, default 128, tuser/metadata width.
REQ-004 SHALL have port arb_aclk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port arb_arst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports arb_s0_valid/arb_s0_ready/arb_s0_data/arb_s0_keep/arb_s0_tlast/arb_s0_tuser  in/out/in/in/in/in  1/1/DATA_W/KEEP_W/1/USER_W  requester 0 AXIS slave.
REQ-007 SHALL have ports arb_s1_valid/arb_s1_ready/arb_s1_data/arb_s1_keep/arb_s1_tlast/arb_s1_tuser  in/out/in/in/in/in  1/1/DATA_W/KEEP_W/1/USER_W  requester 1 AXIS slave.
REQ-008 SHALL have ports arb_m_valid/arb_m_ready/arb_m_data/arb_m_keep/arb_m_tlast/arb_m_tuser  out/in/out/out/out/out  1/1/DATA_W/KEEP_W/1/USER_W  shared AXIS master toward the SDNet tuser input stage.
REQ-009 SHALL have ports arb_pkt_cnt0/arb_pkt_cnt1  out  32 each  packets forwarded per requester.
REQ-010 SHALL have port arb_busy  out  1  high while any grant is held.

Function
REQ-011 SHALL implement FSM states IDLE, GNT0, GNT1; grant granularity is one whole packet.
REQ-012 SHALL, in IDLE, drive arb_m_valid=0, arb_s0_ready=0, arb_s1_ready=0.
REQ-013 SHALL, in IDLE with exactly one sN_valid high, go to GNTN next cycle (one-cycle arbitration latency).
REQ-014 SHALL, in IDLE with both valid high, grant the requester not equal to the last_served pointer.
REQ-015 SHALL, in GNTN, combinationally pass sN data/keep/tlast/tuser/valid to m_*, drive sN_ready=arb_m_ready, other ready=0 (zero-latency datapath).
REQ-016 SHALL define a beat as accepted when arb_m_valid && arb_m_ready.
REQ-017 SHALL hold GNTN across any number of beats and bubbles (sN_valid low) until a tlast beat is accepted.
REQ-018 SHALL, on accepted tlast in GNTN, set last_served=N; go to GNT(1-N) if s(1-N)_valid, else IDLE (no re-grant to N without IDLE pass).
REQ-019 SHALL never assert both sN_ready simultaneously; never switch grant mid-packet.
REQ-020 SHALL increment arb_pkt_cntN by 1 on each accepted tlast beat from requester N; wrap 0xFFFFFFFF->0.
REQ-021 SHALL drive arb_busy=1 in GNT0/GNT1, 0 in IDLE.
REQ-022 SHALL ignore keep/tuser content; single-beat packets (tlast on first beat) are legal.

Reset
REQ-023 SHALL, with arb_arst high at a clock edge, set state=IDLE, last_served=1 (requester 0 wins first tie), counters=0.
REQ-024 SHALL, during/after reset, present arb_m_valid=0, both sN_ready=0, arb_busy=0; m_data/keep/tlast/tuser=0 in IDLE.
REQ-025 SHALL abort a packet in progress on reset mid-packet; no partial-packet recovery is provided.

Structure
REQ-026 SHALL place FSM state encoding (IDLE=2'b00, GNT0=2'b01, GNT1=2'b10) and default widths in shared package p4paxos_axis_pkg.
REQ-027 SHALL be one module; optional sub-module axis_rr_pick (2-way round-robin selector) permitted.

Verification
REQ-028 Reset, then s0 sends 3-beat packet, m_ready=1 -> grant next cycle, 3 beats out unchanged, pkt_cnt0=1, return IDLE.
REQ-029 Both valid from IDLE after reset -> s0 packet first, then s1 immediately (no IDLE cycle), then s0; cnt0=2, cnt1=1.
REQ-030 m_ready toggled 1,0,0,1 during s1 4-beat packet -> s1_ready tracks m_ready, no beat lost/duplicated, s0_ready=0 throughout.
REQ-031 s0 single-beat packets continuously, s1 idle -> alternates GNT0/IDLE, cnt0 increments every 2 cycles.
REQ-032 Force cnt1=0xFFFFFFFF, send one s1 packet -> cnt1=0.
REQ-033 Assert arb_arst on beat 2 of 5-beat s0 packet -> next cycle IDLE, all readies 0, counters 0, next tie grants s0.
